// File: rtl/xcore_img_loader.sv
// Program-image loader: parses a framed byte stream (magic, base, word count,
// data, checksum), writes assembled little-endian words into RAM, and releases
// the core from reset only once the full image has been checksum-verified.
module xcore_img_loader #(
    parameter int unsigned RAM_AW   = 14,
    parameter logic [31:0] RAM_BASE = 32'h8000_0000
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              s_valid,
    input  logic [7:0]        s_data,
    output logic              s_ready,
    input  logic              rearm,
    output logic              ram_we,
    output logic [RAM_AW-1:0] ram_addr,
    output logic [31:0]       ram_wdata,
    output logic              core_rst_n,
    output logic              done,
    output logic              err,
    output logic [1:0]        err_code
);

    typedef enum logic [2:0] {
        StIdle, StAddr, StLen, StData, StCsum, StDone, StErr
    } state_e;

    localparam logic [32:0] RamWords = 33'd1 << RAM_AW;
    localparam logic [7:0]  Magic    = 8'hA5;

    state_e            state_q, state_d;
    logic [31:0]       base_q, base_d;
    logic [15:0]       len_q, len_d;
    logic [1:0]        bcnt_q, bcnt_d;
    logic [15:0]       wcnt_q, wcnt_d;
    logic [7:0]        csum_q, csum_d;
    logic [31:0]       word_q, word_d;
    logic [RAM_AW-1:0] wbase_q, wbase_d;
    logic              we_q, we_d;
    logic [RAM_AW-1:0] addr_q, addr_d;
    logic [31:0]       wdata_q, wdata_d;
    logic [1:0]        code_q, code_d;

    logic        xfer;
    logic [15:0] n_full;
    logic [31:0] base_off;
    logic [32:0] end_w;
    logic        range_bad;

    assign s_ready = !rst && (state_q != StDone) && (state_q != StErr);
    assign xfer    = s_valid && s_ready;

    // Range check on the word count as it completes; 33 bits so nothing wraps.
    assign n_full    = {s_data, len_q[15:8]};
    assign base_off  = base_q - RAM_BASE;
    assign end_w     = {3'b000, base_off[31:2]} + {17'd0, n_full};
    assign range_bad = (base_q < RAM_BASE) || (end_w > RamWords);

    // Next-state: frame parsing, word assembly and checksum accumulation.
    always_comb begin
        state_d = state_q;
        base_d  = base_q;
        len_d   = len_q;
        bcnt_d  = bcnt_q;
        wcnt_d  = wcnt_q;
        csum_d  = csum_q;
        word_d  = word_q;
        wbase_d = wbase_q;
        we_d    = 1'b0;
        addr_d  = addr_q;
        wdata_d = wdata_q;
        code_d  = code_q;
        unique case (state_q)
            StIdle: begin
                if (xfer && s_data == Magic) state_d = StAddr;
            end
            StAddr: begin
                if (xfer) begin
                    base_d = {s_data, base_q[31:8]};
                    bcnt_d = bcnt_q + 2'd1;
                    if (bcnt_q == 2'd3) state_d = StLen;
                end
            end
            StLen: begin
                if (xfer) begin
                    len_d  = n_full;
                    bcnt_d = bcnt_q + 2'd1;
                    if (bcnt_q == 2'd1) begin
                        bcnt_d  = 2'd0;
                        wbase_d = base_off[RAM_AW+1:2];
                        // Misalignment takes priority over range.
                        if (base_q[1:0] != 2'b00) begin
                            state_d = StErr;
                            code_d  = 2'd1;
                        end else if (range_bad) begin
                            state_d = StErr;
                            code_d  = 2'd2;
                        end else if (n_full == 16'd0) begin
                            state_d = StCsum;
                        end else begin
                            state_d = StData;
                        end
                    end
                end
            end
            StData: begin
                if (xfer) begin
                    word_d = {s_data, word_q[31:8]};
                    csum_d = csum_q + s_data;
                    bcnt_d = bcnt_q + 2'd1;
                    if (bcnt_q == 2'd3) begin
                        we_d    = 1'b1;
                        addr_d  = wbase_q + RAM_AW'(wcnt_q);
                        wdata_d = {s_data, word_q[31:8]};
                        wcnt_d  = wcnt_q + 16'd1;
                        if (wcnt_q + 16'd1 == len_q) state_d = StCsum;
                    end
                end
            end
            StCsum: begin
                if (xfer) begin
                    if (s_data == csum_q) begin
                        state_d = StDone;
                    end else begin
                        state_d = StErr;
                        code_d  = 2'd3;
                    end
                end
            end
            StDone: begin
                if (rearm) state_d = StIdle;
            end
            StErr: begin
                if (rearm) begin
                    state_d = StIdle;
                    code_d  = 2'd0;
                end
            end
            default: state_d = StIdle;
        endcase
        // Every entry to IDLE starts the next frame from clean counters.
        if (state_d == StIdle) begin
            bcnt_d = 2'd0;
            wcnt_d = 16'd0;
            csum_d = 8'd0;
        end
    end

    // State and registered outputs, synchronous reset.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= StIdle;
            base_q  <= '0;
            len_q   <= '0;
            bcnt_q  <= '0;
            wcnt_q  <= '0;
            csum_q  <= '0;
            word_q  <= '0;
            wbase_q <= '0;
            we_q    <= 1'b0;
            addr_q  <= '0;
            wdata_q <= '0;
            code_q  <= '0;
        end else begin
            state_q <= state_d;
            base_q  <= base_d;
            len_q   <= len_d;
            bcnt_q  <= bcnt_d;
            wcnt_q  <= wcnt_d;
            csum_q  <= csum_d;
            word_q  <= word_d;
            wbase_q <= wbase_d;
            we_q    <= we_d;
            addr_q  <= addr_d;
            wdata_q <= wdata_d;
            code_q  <= code_d;
        end
    end

    assign ram_we     = we_q;
    assign ram_addr   = addr_q;
    assign ram_wdata  = wdata_q;
    assign done       = (state_q == StDone);
    assign core_rst_n = (state_q == StDone);
    assign err        = (state_q == StErr);
    assign err_code   = code_q;

endmodule

// File: tb/tb_xcore_img_loader.sv
// Bench for xcore_img_loader: builds frames from fields, predicts writes and
// the final status from the frame rules, and compares against the DUT.
module tb_xcore_img_loader;

    localparam int unsigned AW   = 14;
    localparam logic [31:0] BASE = 32'h8000_0000;

    logic          clk = 1'b0;
    logic          rst = 1'b1;
    logic          s_valid = 1'b0;
    logic [7:0]    s_data = 8'h00;
    logic          rearm = 1'b0;
    logic          s_ready;
    logic          ram_we;
    logic [AW-1:0] ram_addr;
    logic [31:0]   ram_wdata;
    logic          core_rst_n;
    logic          done;
    logic          err;
    logic [1:0]    err_code;

    xcore_img_loader #(.RAM_AW(AW), .RAM_BASE(BASE)) dut (
        .clk        (clk),
        .rst        (rst),
        .s_valid    (s_valid),
        .s_data     (s_data),
        .s_ready    (s_ready),
        .rearm      (rearm),
        .ram_we     (ram_we),
        .ram_addr   (ram_addr),
        .ram_wdata  (ram_wdata),
        .core_rst_n (core_rst_n),
        .done       (done),
        .err        (err),
        .err_code   (err_code)
    );

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    logic [63:0] got_wr[$];
    int          got_cyc[$];
    always @(negedge clk) begin
        if (ram_we) begin
            got_wr.push_back({32'(ram_addr), ram_wdata});
            got_cyc.push_back(cyc);
        end
    end

    int          n_pass = 0;
    int          n_total = 0;
    logic [7:0]  dat[$];
    logic [7:0]  frm[$];
    logic [63:0] exp_wr[$];
    int          exp_code;
    int          last_xfer_cyc;
    bit          timed_out;
    logic [4:0]  exp_st;

    function automatic logic [7:0] sum8();
        logic [7:0] s = 8'h00;
        foreach (dat[i]) s = s + dat[i];
        return s;
    endfunction

    function automatic void fill_data(input int n);
        dat = {};
        for (int i = 0; i < 4 * n; i++) dat.push_back(8'($urandom_range(0, 255)));
    endfunction

    function automatic void nominal_data();
        dat = {8'h11, 8'h22, 8'h33, 8'h44, 8'h55, 8'h66, 8'h77, 8'h88};
    endfunction

    // Reference model: frame bytes plus predicted writes and outcome code (0 = done).
    function automatic void prepare(input logic [31:0] base, input int n, input logic [7:0] cs);
        longint     off;
        logic [15:0] n16 = 16'(n);
        frm = {};
        exp_wr = {};
        frm.push_back(8'hA5);
        for (int i = 0; i < 4; i++) frm.push_back(base[8*i +: 8]);
        frm.push_back(n16[7:0]);
        frm.push_back(n16[15:8]);
        foreach (dat[i]) frm.push_back(dat[i]);
        frm.push_back(cs);
        if (base[1:0] != 2'b00) begin
            exp_code = 1;
        end else if (base < BASE ||
                     (longint'(base - BASE) / 4) + longint'(n) > (longint'(1) << AW)) begin
            exp_code = 2;
        end else begin
            off = longint'(base - BASE) / 4;
            for (int k = 0; k < n; k++)
                exp_wr.push_back({32'(off + k), dat[4*k+3], dat[4*k+2], dat[4*k+1], dat[4*k]});
            exp_code = (cs == sum8()) ? 0 : 3;
        end
        exp_st = (exp_code == 0) ? 5'b1_0_00_1 : {1'b0, 1'b1, 2'(exp_code), 1'b0};
    endfunction

    // Drives frm[0..count-1]; starts and ends on a falling edge.
    task automatic send(input int count, input int gap, input bit noise);
        timed_out = 0;
        for (int i = 0; i < count && !timed_out; i++) begin
            int t = 0;
            s_valid = 1'b1;
            s_data  = frm[i];
            while (!s_ready && !timed_out) begin
                @(negedge clk);
                t++;
                if (t > 20) timed_out = 1;
            end
            if (!timed_out) begin
                if (noise) rearm = 1'($urandom_range(0, 1));
                @(posedge clk);
                @(negedge clk);
                rearm = 1'b0;
                last_xfer_cyc = cyc;
                for (int g = 0; g < gap; g++) begin
                    s_valid = 1'b0;
                    @(negedge clk);
                end
            end
        end
        s_valid = 1'b0;
        if (timed_out) begin
            n_total++;
            $display("FAIL send_timeout: s_ready=0 for >20 cycles, required 1");
        end
    endtask

    task automatic do_rearm();
        rearm = 1'b1;
        @(negedge clk);
        rearm = 1'b0;
    endtask

    task automatic test_reset();
        rst = 1'b1;
        @(negedge clk);
        @(negedge clk);
        n_total++;
        if (s_ready !== 1'b0) $display("FAIL reset_ready: got %b want 0", s_ready);
        else n_pass++;
        n_total++;
        if ({ram_we, ram_addr, ram_wdata, core_rst_n, done, err, err_code} !== '0)
            $display("FAIL reset_outputs: got we=%b a=%0h d=%h crn=%b dn=%b er=%b c=%0d want all 0",
                     ram_we, ram_addr, ram_wdata, core_rst_n, done, err, err_code);
        else n_pass++;
        rst = 1'b0;
        @(negedge clk);
        n_total++;
        if (s_ready !== 1'b1) $display("FAIL reset_ready_after: got %b want 1", s_ready);
        else n_pass++;
    endtask

    task automatic test_nominal();
        nominal_data();
        prepare(32'h8000_0010, 2, 8'h64);
        got_wr = {}; got_cyc = {};
        send(frm.size(), 0, 0);
        n_total++;
        if ({done, err, err_code, core_rst_n} !== 5'b1_0_00_1)
            $display("FAIL nominal_status: got %b want 10001", {done, err, err_code, core_rst_n});
        else n_pass++;
        n_total++;
        if (got_wr.size() != 2) $display("FAIL nominal_nwr: got %0d want 2", got_wr.size());
        else begin
            n_pass++;
            n_total++;
            if (got_wr[0] !== {32'd4, 32'h4433_2211} || got_wr[1] !== {32'd5, 32'h8877_6655})
                $display("FAIL nominal_words: got %h %h want 4:44332211 5:88776655",
                         got_wr[0], got_wr[1]);
            else n_pass++;
            n_total++;
            if (got_cyc[1] - got_cyc[0] != 4 || got_cyc[1] + 1 != last_xfer_cyc)
                $display("FAIL nominal_timing: wr@%0d,%0d csum@%0d want spacing 4, csum 1 later",
                         got_cyc[0], got_cyc[1], last_xfer_cyc);
            else n_pass++;
        end
        do_rearm();
        n_total++;
        if ({done, core_rst_n} !== 2'b00) $display("FAIL rearm_done: got %b want 00", {done, core_rst_n});
        else n_pass++;
    endtask

    task automatic test_resync();
        nominal_data();
        prepare(32'h8000_0010, 2, 8'h64);
        frm.push_front(8'hFF);
        frm.push_front(8'h00);
        got_wr = {};
        send(frm.size(), 0, 1);
        n_total++;
        if ({done, err, err_code, core_rst_n} !== exp_st || got_wr != exp_wr)
            $display("FAIL resync: got st=%b nwr=%0d want st=%b nwr=%0d",
                     {done, err, err_code, core_rst_n}, got_wr.size(), exp_st, exp_wr.size());
        else n_pass++;
        do_rearm();
    endtask

    task automatic test_errors();
        logic [31:0] bases[4] = '{32'h8000_0002, 32'h7FFF_FFFC, 32'h8000_FFFC, 32'h8000_FFFC};
        int          ns[4]    = '{2, 1, 2, 1};
        int          codes[4] = '{1, 2, 2, 0};
        for (int c = 0; c < 4; c++) begin
            fill_data(ns[c]);
            prepare(bases[c], ns[c], sum8());
            got_wr = {};
            send((exp_code == 1 || exp_code == 2) ? 7 : frm.size(), 0, 0);
            n_total++;
            if (exp_code != codes[c] || {done, err, err_code, core_rst_n} !== exp_st)
                $display("FAIL err_case%0d: got st=%b want code %0d", c,
                         {done, err, err_code, core_rst_n}, codes[c]);
            else n_pass++;
            n_total++;
            if (got_wr != exp_wr || s_ready !== 1'b0)
                $display("FAIL err_case%0d_wr: got nwr=%0d rdy=%b want nwr=%0d rdy=0", c,
                         got_wr.size(), s_ready, exp_wr.size());
            else n_pass++;
            do_rearm();
        end
    endtask

    task automatic test_csum_fault();
        nominal_data();
        prepare(32'h8000_0010, 2, 8'h65);
        got_wr = {};
        send(frm.size(), 0, 0);
        n_total++;
        if ({done, err, err_code, core_rst_n} !== 5'b0_1_11_0 || got_wr != exp_wr)
            $display("FAIL csum_fault: got st=%b nwr=%0d want 01110 nwr=2",
                     {done, err, err_code, core_rst_n}, got_wr.size());
        else n_pass++;
        do_rearm();
        n_total++;
        if ({err, err_code} !== 3'b000) $display("FAIL csum_rearm: got %b want 000", {err, err_code});
        else n_pass++;
        prepare(32'h8000_0010, 2, 8'h64);
        send(frm.size(), 0, 0);
        n_total++;
        if ({done, err, core_rst_n} !== 3'b101)
            $display("FAIL csum_reload: got %b want 101", {done, err, core_rst_n});
        else n_pass++;
        do_rearm();
    endtask

    task automatic test_zero_len();
        dat = {};
        prepare(32'h8000_0100, 0, 8'h00);
        got_wr = {};
        send(frm.size(), 0, 0);
        n_total++;
        if ({done, err, core_rst_n} !== 3'b101 || got_wr.size() != 0)
            $display("FAIL zero_len: got st=%b nwr=%0d want 101 nwr=0",
                     {done, err, core_rst_n}, got_wr.size());
        else n_pass++;
        do_rearm();
    endtask

    task automatic test_mid_reset();
        nominal_data();
        prepare(32'h8000_0010, 2, 8'h64);
        got_wr = {};
        send(10, 0, 0);
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        repeat (4) @(negedge clk);
        n_total++;
        if (got_wr.size() != 0 || core_rst_n !== 1'b0 || s_ready !== 1'b1)
            $display("FAIL mid_reset: got nwr=%0d crn=%b rdy=%b want 0 0 1",
                     got_wr.size(), core_rst_n, s_ready);
        else n_pass++;
        send(frm.size(), 0, 0);
        n_total++;
        if ({done, err, err_code, core_rst_n} !== exp_st || got_wr != exp_wr)
            $display("FAIL mid_reset_reload: got st=%b nwr=%0d want st=%b nwr=%0d",
                     {done, err, err_code, core_rst_n}, got_wr.size(), exp_st, exp_wr.size());
        else n_pass++;
        do_rearm();
    endtask

    task automatic test_gapped();
        nominal_data();
        prepare(32'h8000_0010, 2, 8'h64);
        got_wr = {}; got_cyc = {};
        send(frm.size(), 1, 0);
        n_total++;
        if ({done, err, err_code, core_rst_n} !== exp_st || got_wr != exp_wr)
            $display("FAIL gapped: got st=%b nwr=%0d want st=%b nwr=%0d",
                     {done, err, err_code, core_rst_n}, got_wr.size(), exp_st, exp_wr.size());
        else n_pass++;
        n_total++;
        if (got_cyc.size() != 2 || got_cyc[1] - got_cyc[0] != 8)
            $display("FAIL gapped_spacing: got %0d writes, want 2 spaced 8", got_cyc.size());
        else n_pass++;
        do_rearm();
    endtask

    task automatic test_random();
        for (int it = 0; it < 25; it++) begin
            int          n = $urandom_range(0, 5);
            int          r = $urandom_range(0, 9);
            logic [31:0] base = BASE + 32'(4 * $urandom_range(0, (1 << AW) - 1));
            logic [7:0]  cs;
            if (r == 7) base = base | 32'($urandom_range(1, 3));
            if (r == 8) base = {1'b0, 31'($urandom)};
            if (r == 9) base = BASE + 32'(4 * ((1 << AW) - $urandom_range(0, 6)));
            fill_data(n);
            cs = sum8();
            if ($urandom_range(0, 3) == 0) cs = cs ^ 8'($urandom_range(1, 255));
            prepare(base, n, cs);
            got_wr = {};
            send((exp_code == 1 || exp_code == 2) ? 7 : frm.size(), $urandom_range(0, 2), 1);
            n_total++;
            if ({done, err, err_code, core_rst_n} !== exp_st || got_wr != exp_wr)
                $display("FAIL random%0d: base=%h n=%0d got st=%b nwr=%0d want st=%b nwr=%0d",
                         it, base, n, {done, err, err_code, core_rst_n}, got_wr.size(),
                         exp_st, exp_wr.size());
            else n_pass++;
            do_rearm();
        end
    endtask

    initial begin
        test_reset();
        test_nominal();
        test_resync();
        test_errors();
        test_csum_fault();
        test_zero_len();
        test_mid_reset();
        test_gapped();
        test_random();
        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation did not finish, required completion");
        $fatal(1);
    end

endmodule
